uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmitter between NREQ byte-producing requesters. It sits between the requesters and the transmitter's tx_en/tx_data/tx_busy/tx_done/tx_rst pins. It sequences one byte at a time and guards each transfer with a completion watchdog.

---
 rtl/uart_sched_pkg.sv | 25 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 33 +++
 rtl/uart_tx_sched.sv | 174 +++++++++++++++++
 tb/tb_uart_tx_sched.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and helpers for the UART transmit scheduler and its round-robin arbiter.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_WAIT   = 3'd2,
    S_ABORT  = 3'd3,
    S_HSTART = 3'd4,
    S_HWAIT  = 3'd5
  } sched_state_e;

  localparam logic [7:0] HDR_BASE = 8'hA0;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Combinational round-robin winner search starting one past the last winner.
module rr_arbiter
  import uart_sched_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]                 valid_i,
  input  logic [clog2_min1(NREQ)-1:0]     ptr_i,
  output logic                            any_o,
  output logic [NREQ-1:0]                 onehot_o,
  output logic [clog2_min1(NREQ)-1:0]     idx_o
);

  localparam int IW = clog2_min1(NREQ);

  // Walk the ring from ptr+1; the first valid requester wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    found    = 1'b0;
    cand     = '0;
    onehot_o = '0;
    idx_o    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand           = IW'((int'(ptr_i) + k) % NREQ);
      onehot_o[cand] = valid_i[cand] & ~found;
      idx_o          = (valid_i[cand] & ~found) ? cand : idx_o;
      found          = found | valid_i[cand];
    end
    any_o = found;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter between NREQ requesters, with a
// completion watchdog. Define UART_SCHED_HDR_EN to prefix each grant with a header byte.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int              NREQ    = 4,
  parameter int              WIDTH8  = 8,
  parameter int              TO_W    = 16,
  parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
  input  logic                          PCLK,
  input  logic                          PRESETn,
  input  logic [NREQ-1:0]               req_valid,
  input  logic [NREQ*WIDTH8-1:0]        req_data,
  output logic [NREQ-1:0]               req_ready,
  input  logic                          tx_busy,
  input  logic                          tx_done,
  output logic                          tx_en,
  output logic                          tx_rst,
  output logic [WIDTH8-1:0]             tx_data,
  output logic [clog2_min1(NREQ)-1:0]   grant_id,
  output logic                          active,
  output logic                          err,
  output logic [clog2_min1(NREQ)-1:0]   err_id
);

  localparam int              IW      = clog2_min1(NREQ);
  localparam logic [TO_W-1:0] WD_LAST = TIMEOUT - TO_W'(1);

  sched_state_e      state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [IW-1:0]     err_id_q, err_id_d;
  logic [WIDTH8-1:0] data_q, data_d;
  logic [TO_W-1:0]   wd_q, wd_d;
  logic              err_q, tx_rst_q, active_q;
  logic              tx_en_s;
  logic              any_s;
  logic [NREQ-1:0]   onehot_s;
  logic [IW-1:0]     win_s;
`ifdef UART_SCHED_HDR_EN
  logic [WIDTH8-1:0] payload_q, payload_d;
`endif

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .valid_i  (req_valid),
    .ptr_i    (ptr_q),
    .any_o    (any_s),
    .onehot_o (onehot_s),
    .idx_o    (win_s)
  );

  // Next-state, datapath and start-pulse decode.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    data_d   = data_q;
    wd_d     = wd_q;
    err_id_d = err_id_q;
    tx_en_s  = 1'b0;
`ifdef UART_SCHED_HDR_EN
    payload_d = payload_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (any_s) begin
          ptr_d   = win_s;
          grant_d = win_s;
`ifdef UART_SCHED_HDR_EN
          data_d    = WIDTH8'(HDR_BASE) | WIDTH8'(win_s);
          payload_d = req_data[int'(win_s)*WIDTH8 +: WIDTH8];
          state_d   = S_HSTART;
`else
          data_d  = req_data[int'(win_s)*WIDTH8 +: WIDTH8];
          state_d = S_START;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (!tx_busy) begin
          tx_en_s = 1'b1;
          wd_d    = '0;
          state_d = S_WAIT;
        end else begin
          state_d = S_START;
        end
      end
      S_WAIT: begin
        // A done arriving on the timeout cycle still counts as success.
        if (tx_done) begin
          state_d = S_IDLE;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_ABORT;
          err_id_d = grant_q;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      S_ABORT: begin
        state_d = S_IDLE;
      end
`ifdef UART_SCHED_HDR_EN
      S_HSTART: begin
        if (!tx_busy) begin
          tx_en_s = 1'b1;
          wd_d    = '0;
          state_d = S_HWAIT;
        end else begin
          state_d = S_HSTART;
        end
      end
      S_HWAIT: begin
        if (tx_done) begin
          data_d  = payload_q;
          state_d = S_START;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_ABORT;
          err_id_d = grant_q;
        end else begin
          wd_d = wd_q + TO_W'(1);
        end
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, datapath and registered status outputs.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      ptr_q    <= IW'(NREQ - 1);
      grant_q  <= '0;
      err_id_q <= '0;
      data_q   <= '0;
      wd_q     <= '0;
      err_q    <= 1'b0;
      tx_rst_q <= 1'b0;
      active_q <= 1'b0;
`ifdef UART_SCHED_HDR_EN
      payload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      err_id_q <= err_id_d;
      data_q   <= data_d;
      wd_q     <= wd_d;
      err_q    <= (state_d == S_ABORT);
      tx_rst_q <= (state_d == S_ABORT);
      active_q <= (state_d != S_IDLE);
`ifdef UART_SCHED_HDR_EN
      payload_q <= payload_d;
`endif
    end
  end

  // Accept is offered only while idle and out of reset.
  assign req_ready = (state_q == S_IDLE && PRESETn) ? onehot_s : '0;
  assign tx_en     = tx_en_s;
  assign tx_rst    = tx_rst_q;
  assign tx_data   = data_q;
  assign grant_id  = grant_q;
  assign active    = active_q;
  assign err       = err_q;
  assign err_id    = err_id_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized scoreboard bench for uart_tx_sched with a behavioural transmitter and scheduler model.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int TOUT = 16;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] gid;
    logic       hdr;
  } exp_t;

  logic              PCLK = 1'b0;
  logic              PRESETn = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ*8-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              tx_busy = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_en, tx_rst, active, err;
  logic [7:0]        tx_data;
  logic [1:0]        grant_id, err_id;

  uart_tx_sched #(.NREQ(NREQ), .WIDTH8(8), .TO_W(16), .TIMEOUT(16'(TOUT))) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_busy(tx_busy), .tx_done(tx_done), .tx_en(tx_en),
    .tx_rst(tx_rst), .tx_data(tx_data), .grant_id(grant_id), .active(active),
    .err(err), .err_id(err_id)
  );

  initial forever #5 PCLK = ~PCLK;

  int cyc = 0;
  initial forever begin
    @(posedge PCLK);
    cyc = cyc + 1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Per-requester byte queues; front element is what the requester presents.
  logic [7:0] src_q[NREQ][$];

  initial begin
    logic [NREQ-1:0] hs;
    forever begin
      @(negedge PCLK);
      hs = req_valid & req_ready;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        req_valid[i] = (src_q[i].size() > 0);
        req_data[i*8 +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Transmitter model: mode 0 done after dir_k cycles, 1 never done, 2 done on the timeout cycle.
  int mode = 0;
  int dir_k = 10;
  bit rand_mode = 1'b0;
  int done_at = -1;
  int busy_until = -1;

  initial begin
    int m, k, r;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        done_at = -1;
        busy_until = -1;
      end else if (tx_en) begin
        m = mode;
        k = dir_k;
        if (rand_mode) begin
          r = $urandom_range(0, 9);
          m = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
          k = $urandom_range(1, 14);
        end
        if (m == 1) begin
          done_at = -1;
          busy_until = cyc + TOUT + 1;
        end else begin
          if (m == 2) k = TOUT;
          done_at = cyc + k;
          busy_until = done_at + (rand_mode ? $urandom_range(0, 3) : 0);
        end
      end
      @(posedge PCLK);
      #1;
      tx_done = PRESETn && (cyc == done_at);
      tx_busy = PRESETn && (cyc <= busy_until);
    end
  end

  // Reference model state.
  exp_t       exp_q[$];
  int         ptr_m, start_at, release_at, err_at, en_cyc, active_from, cur_gid;
  bit         owned, inflight, cur_hdr;
  logic [7:0] cur_data;
  logic [1:0] err_id_m;

  task automatic model_reset();
    exp_q.delete();
    ptr_m = NREQ - 1;
    start_at = -1;
    release_at = -1;
    err_at = -1;
    en_cyc = -100;
    active_from = 1 << 30;
    cur_gid = 0;
    owned = 1'b0;
    inflight = 1'b0;
    cur_hdr = 1'b0;
    cur_data = 8'h00;
    err_id_m = 2'd0;
  endtask

  initial model_reset();

  // Monitor: compare every DUT output against the model once per cycle.
  initial begin
    int w, j;
    logic [NREQ-1:0] exp_rdy;
    bit exp_en;
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (!PRESETn) begin
        model_reset();
      end else begin
        if (release_at == cyc) begin
          owned = 1'b0;
          release_at = -1;
        end
        exp_rdy = '0;
        w = -1;
        if (!owned && req_valid != '0) begin
          for (int k = 1; k <= NREQ; k++) begin
            j = (ptr_m + k) % NREQ;
            if (w < 0 && req_valid[j]) w = j;
          end
          exp_rdy[w] = 1'b1;
        end
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (w >= 0) begin
          ptr_m = w;
          owned = 1'b1;
          active_from = cyc + 1;
          start_at = cyc + 1;
          cur_gid = w;
`ifdef UART_SCHED_HDR_EN
          exp_q.push_back('{data: 8'hA0 | 8'(w), gid: 2'(w), hdr: 1'b1});
`endif
          exp_q.push_back('{data: src_q[w][0], gid: 2'(w), hdr: 1'b0});
        end
        chk("active", 64'(active), 64'(owned && cyc >= active_from));
        if (owned && cyc >= active_from) chk("grant_id", 64'(grant_id), 64'(cur_gid));
        exp_en = (start_at >= 0 && cyc >= start_at && !tx_busy);
        chk("tx_en", 64'(tx_en), 64'(exp_en));
        if (tx_en && exp_en) begin
          if (exp_q.size() == 0) begin
            chk("exp_q_nonempty", 64'(0), 64'(1));
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", 64'(tx_data), 64'(e.data));
            cur_hdr = e.hdr;
            cur_data = e.data;
          end
          start_at = -1;
          en_cyc = cyc;
          inflight = 1'b1;
        end else if (inflight) begin
          chk("tx_data_hold", 64'(tx_data), 64'(cur_data));
          if (tx_done) begin
            inflight = 1'b0;
            if (cur_hdr) start_at = cyc + 1;
            else release_at = cyc + 1;
          end else if (cyc == en_cyc + TOUT) begin
            inflight = 1'b0;
            err_at = cyc + 1;
          end
        end
        chk("err", 64'(err), 64'(cyc == err_at));
        chk("tx_rst", 64'(tx_rst), 64'(cyc == err_at));
        if (cyc == err_at) begin
          err_id_m = 2'(cur_gid);
          release_at = cyc + 1;
          err_at = -1;
          if (cur_hdr && exp_q.size() > 0) void'(exp_q.pop_front());
        end
        chk("err_id", 64'(err_id), 64'(err_id_m));
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < budget) begin
      @(posedge PCLK);
      n = n + 1;
      pend = owned || inflight;
      for (int i = 0; i < NREQ; i++) if (src_q[i].size() > 0) pend = 1'b1;
    end
    chk("wait_idle_timeout", 64'(pend), 64'(0));
    repeat (2) @(posedge PCLK);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_tx_en"}, 64'(tx_en), 64'(0));
    chk({tag, "_tx_rst"}, 64'(tx_rst), 64'(0));
    chk({tag, "_err"}, 64'(err), 64'(0));
    chk({tag, "_active"}, 64'(active), 64'(0));
    chk({tag, "_grant_id"}, 64'(grant_id), 64'(0));
    chk({tag, "_err_id"}, 64'(err_id), 64'(0));
    chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
    chk({tag, "_req_ready"}, 64'(req_ready), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    int n;
    repeat (3) @(posedge PCLK);
    #1;
    check_outputs_zero("reset");
    @(posedge PCLK);
    #3 PRESETn = 1'b1;

    // Requesters 1 and 3 after reset, then 3 alone.
    @(posedge PCLK);
    src_q[1].push_back(8'($urandom));
    src_q[3].push_back(8'($urandom));
    wait_idle(300);
    src_q[3].push_back(8'($urandom));
    wait_idle(300);

    // Single byte from requester 0, done after 10 cycles.
    mode = 0;
    dir_k = 10;
    src_q[0].push_back(8'h55);
    wait_idle(300);

    // All requesters continuously valid.
    dir_k = 5;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'($urandom));
    wait_idle(600);

    // Watchdog abort, then the next requester is served.
    mode = 1;
    src_q[1].push_back(8'($urandom));
    src_q[2].push_back(8'($urandom));
    n = 0;
    do begin
      @(posedge PCLK);
      #1;
      n = n + 1;
    end while (!err && n < 200);
    chk("abort_seen", 64'(err), 64'(1));
    mode = 0;
    wait_idle(400);

    // Done on exactly the timeout cycle.
    mode = 2;
    src_q[0].push_back(8'($urandom));
    wait_idle(300);
    mode = 0;

    // Randomized traffic with random completion behaviour and trailing busy.
    rand_mode = 1'b1;
    repeat (60) begin
      @(posedge PCLK);
      src_q[$urandom_range(0, NREQ - 1)].push_back(8'($urandom));
      repeat ($urandom_range(0, 20)) @(posedge PCLK);
    end
    wait_idle(6000);
    rand_mode = 1'b0;

    // Reset in the middle of a frame.
    mode = 0;
    dir_k = 14;
    src_q[2].push_back(8'($urandom));
    n = 0;
    do begin
      @(posedge PCLK);
      n = n + 1;
    end while (!(inflight && cyc >= en_cyc + 3) && n < 100);
    chk("reached_wait", 64'(inflight), 64'(1));
    @(posedge PCLK);
    #3 PRESETn = 1'b0;
    #1;
    check_outputs_zero("midreset");
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(8'($urandom));
    repeat (2) @(posedge PCLK);
    #3 PRESETn = 1'b1;
    n = 0;
    do begin
      @(negedge PCLK);
      n = n + 1;
    end while (req_ready == '0 && n < 20);
    chk("first_grant_after_reset", 64'(req_ready), 64'(4'b0001));
    wait_idle(600);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
